// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Register id and word types are reused by the register file and its writeback sources.
package rf_wb_arbiter_pkg;

    localparam int WB_NREQ = 2;
    localparam int REGID_W = 5;
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 16;

    typedef logic [REGID_W-1:0] regid_t;
    typedef logic [WORD_W-1:0]  word_t;

    typedef struct packed {
        logic   valid;
        regid_t addr;
        word_t  data;
    } wb_stage_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: requester handshake, register-file write port and forwarding ports.
// The arbiter sits on the slave side; sources, register file and readers on the master side.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ
);

    logic                  stall;
    logic   [NREQ-1:0]     req_valid;
    regid_t [NREQ-1:0]     req_addr;
    word_t  [NREQ-1:0]     req_data;
    logic   [NREQ-1:0]     req_ready;

    logic                  w_enable;
    regid_t                w_addr;
    word_t                 w_data;

    regid_t                fwd1_addr;
    regid_t                fwd2_addr;
    logic                  fwd1_hit;
    logic                  fwd2_hit;
    word_t                 fwd1_data;
    word_t                 fwd2_data;

    modport slave (
        input  stall,
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output w_enable,
        output w_addr,
        output w_data,
        input  fwd1_addr,
        input  fwd2_addr,
        output fwd1_hit,
        output fwd2_hit,
        output fwd1_data,
        output fwd2_data
    );

    modport master (
        output stall,
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  w_enable,
        input  w_addr,
        input  w_data,
        output fwd1_addr,
        output fwd2_addr,
        input  fwd1_hit,
        input  fwd2_hit,
        input  fwd1_data,
        input  fwd2_data
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above i_ptr, wrapping.
// Generic so other shared resources can reuse it.
module rr_arbiter #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    input  logic         i_en,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_gnt_idx
);

    logic w_found;

    // Two passes: the upper segment [ptr, N) has priority over the wrapped segment [0, ptr).
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        if (i_en) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
                    o_gnt[i]  = 1'b1;
                    o_gnt_idx = W'(i);
                    w_found   = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_req[i] && (i < int'(i_ptr))) begin
                    o_gnt[i]  = 1'b1;
                    o_gnt_idx = W'(i);
                    w_found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single write-port arbiter for the register file: round-robin grant, one registered
// write stage, x0 drop, two forwarding compares and a saturating contention counter.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ    = WB_NREQ,
    parameter bit DROP_X0 = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rf_wb_arbiter_if.slave       wb,
    output logic [CNT_W-1:0]     o_conflict_cnt
);

    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0]    r_rr_ptr;
    wb_stage_t        r_stage;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_arb_en;
    logic             w_xfer;
    logic             w_multi;
    regid_t           w_sel_addr;
    word_t            w_sel_data;

    // Reset gates the grant so no requester completes a transfer that the reset would discard.
    assign w_arb_en = ~wb.stall & ~i_rst;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .i_req     (wb.req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (w_arb_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign wb.req_ready = w_gnt;
    assign w_xfer       = |w_gnt;
    assign w_sel_addr   = wb.req_addr[w_gnt_idx];
    assign w_sel_data   = wb.req_data[w_gnt_idx];

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign w_multi = |(wb.req_valid & (wb.req_valid - NREQ'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= PW'(rr_next(int'(w_gnt_idx), NREQ));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage <= '0;
        end else if (w_xfer) begin
            r_stage.valid <= !(DROP_X0 && (w_sel_addr == '0));
            r_stage.addr  <= w_sel_addr;
            r_stage.data  <= w_sel_data;
        end else begin
            r_stage.valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_conflict_cnt <= '0;
        end else if (w_multi && !wb.stall && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign wb.w_enable = r_stage.valid;
    assign wb.w_addr   = r_stage.addr;
    assign wb.w_data   = r_stage.data;

    assign wb.fwd1_hit  = r_stage.valid && (r_stage.addr == wb.fwd1_addr);
    assign wb.fwd2_hit  = r_stage.valid && (r_stage.addr == wb.fwd2_addr);
    assign wb.fwd1_data = wb.fwd1_hit ? r_stage.data : '0;
    assign wb.fwd2_data = wb.fwd2_hit ? r_stage.data : '0;

    assign o_conflict_cnt = r_conflict_cnt;

endmodule
